// File: rtl/game_pkg.sv
// Shared game definitions: movement directions, chaser states and grid geometry.
package game_pkg;

  localparam int unsigned CELL_SIZE = 32;

  // Same coding as player_direction
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } direction_t;

  typedef enum logic [1:0] {
    CHASE_IDLE   = 2'd0,
    CHASE_DECIDE = 2'd1,
    CHASE_MOVE   = 2'd2,
    CHASE_ESCAPE = 2'd3
  } chase_state_t;

  // One-hot arrow vector indexed by direction code: [0]=up [1]=right [2]=down [3]=left
  function automatic logic [3:0] dir_to_arrows(input direction_t dir);
    return 4'b0001 << dir;
  endfunction

  // Opposite direction on the same axis (flips the axis-sign bit of the coding)
  function automatic direction_t dir_reverse(input direction_t dir);
    return direction_t'(dir ^ 2'b10);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) providing the chaser's tie-break bit.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tie_bit
);

  logic [7:0] lfsr_q;

  // Shift left once per enable; XOR of taps feeds bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign tie_bit = lfsr_q[0];

endmodule

// File: rtl/enemy_arrowcommander.sv
// Arrow command source for an enemy movement block: chases the player on the
// grid, turning only at cell corners, with a timed detour when blocked.
module enemy_arrowcommander
  import game_pkg::*;
#(
  parameter int unsigned CELL_BITS     = $clog2(CELL_SIZE),
  parameter int unsigned STALL_FRAMES  = 4,
  parameter int unsigned ESCAPE_FRAMES = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               player_awake,
  input  logic signed [10:0] player_topLeftX,
  input  logic signed [10:0] player_topLeftY,
  input  logic signed [10:0] enemy_topLeftX,
  input  logic signed [10:0] enemy_topLeftY,
  output logic               leftArrow,
  output logic               rightArrow,
  output logic               upArrow,
  output logic               downArrow,
  output logic               chasing
);

  localparam int unsigned STALL_W = $clog2(STALL_FRAMES + 1);
  localparam int unsigned ESC_W   = $clog2(ESCAPE_FRAMES + 1);

  chase_state_t       state_q, state_d;
  direction_t         dir_q, dir_d;
  logic               drive_q, drive_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [ESC_W-1:0]   esc_q, esc_d;
  logic               reversed_q, reversed_d;
  logic signed [10:0] prev_x_q, prev_y_q, prev_x_d, prev_y_d;
  logic [3:0]         arrows_d;
  logic               tie_bit;
  logic               do_seek;

  logic signed [11:0] dx, dy;
  logic [11:0]        adx, ady;
  logic               diff_zero, aligned, stalled_pos;
  direction_t         seek_dir, side_dir;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .en      (startOfFrame),
    .tie_bit (tie_bit)
  );

  assign dx  = {player_topLeftX[10], player_topLeftX} - {enemy_topLeftX[10], enemy_topLeftX};
  assign dy  = {player_topLeftY[10], player_topLeftY} - {enemy_topLeftY[10], enemy_topLeftY};
  assign adx = dx[11] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[11] ? $unsigned(-dy) : $unsigned(dy);

  assign diff_zero   = (dx == '0) && (dy == '0);
  assign aligned     = (enemy_topLeftX[CELL_BITS-1:0] == '0) && (enemy_topLeftY[CELL_BITS-1:0] == '0);
  assign stalled_pos = (enemy_topLeftX == prev_x_q) && (enemy_topLeftY == prev_y_q);

  // Seek direction along the dominant axis, and the detour direction on the other axis
  always_comb begin
    if ((adx > ady) || ((adx == ady) && tie_bit)) begin
      seek_dir = dx[11] ? DIR_LEFT : DIR_RIGHT;
    end else begin
      seek_dir = dy[11] ? DIR_UP : DIR_DOWN;
    end
    if (dir_q[0]) begin
      if (dy == '0) side_dir = tie_bit ? DIR_DOWN : DIR_UP;
      else          side_dir = dy[11] ? DIR_UP : DIR_DOWN;
    end else begin
      if (dx == '0) side_dir = tie_bit ? DIR_RIGHT : DIR_LEFT;
      else          side_dir = dx[11] ? DIR_LEFT : DIR_RIGHT;
    end
  end

  // Next-state logic; everything except abort happens only in the frame-pulse cycle
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    drive_d    = drive_q;
    stall_d    = stall_q;
    esc_d      = esc_q;
    reversed_d = reversed_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    do_seek    = 1'b0;

    if (!(enable && player_awake)) begin
      state_d = CHASE_IDLE;
      drive_d = 1'b0;
    end else if (startOfFrame) begin
      prev_x_d = enemy_topLeftX;
      prev_y_d = enemy_topLeftY;
      case (state_q)
        CHASE_IDLE: begin
          stall_d    = '0;
          esc_d      = '0;
          reversed_d = 1'b0;
          do_seek    = 1'b1;
        end
        CHASE_DECIDE: begin
          stall_d = '0;
          do_seek = 1'b1;
        end
        CHASE_MOVE: begin
          stall_d = stalled_pos ? stall_q + STALL_W'(1) : '0;
          // Stall wins over a corner re-decision on the same pulse
          if (stall_d >= STALL_W'(STALL_FRAMES)) begin
            state_d    = CHASE_ESCAPE;
            dir_d      = side_dir;
            drive_d    = 1'b1;
            stall_d    = '0;
            esc_d      = '0;
            reversed_d = 1'b0;
          end else if (aligned) begin
            do_seek = 1'b1;
          end
        end
        CHASE_ESCAPE: begin
          stall_d = stalled_pos ? stall_q + STALL_W'(1) : '0;
          if (stall_d >= STALL_W'(STALL_FRAMES)) begin
            stall_d = '0;
            if (!reversed_q) begin
              dir_d      = dir_reverse(dir_q);
              esc_d      = '0;
              reversed_d = 1'b1;
            end else begin
              state_d = CHASE_DECIDE;
            end
          end else begin
            esc_d = esc_q + ESC_W'(1);
            if (esc_d == ESC_W'(ESCAPE_FRAMES)) state_d = CHASE_DECIDE;
          end
        end
        default: state_d = CHASE_IDLE;
      endcase

      if (do_seek) begin
        if (diff_zero) begin
          state_d = CHASE_DECIDE;
          drive_d = 1'b0;
        end else begin
          state_d = CHASE_MOVE;
          dir_d   = seek_dir;
          drive_d = 1'b1;
        end
      end
    end

    arrows_d = drive_d ? dir_to_arrows(dir_d) : '0;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CHASE_IDLE;
      dir_q      <= DIR_UP;
      drive_q    <= 1'b0;
      stall_q    <= '0;
      esc_q      <= '0;
      reversed_q <= 1'b0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      upArrow    <= 1'b0;
      rightArrow <= 1'b0;
      downArrow  <= 1'b0;
      leftArrow  <= 1'b0;
      chasing    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      drive_q    <= drive_d;
      stall_q    <= stall_d;
      esc_q      <= esc_d;
      reversed_q <= reversed_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      upArrow    <= arrows_d[0];
      rightArrow <= arrows_d[1];
      downArrow  <= arrows_d[2];
      leftArrow  <= arrows_d[3];
      chasing    <= (state_d == CHASE_MOVE) || (state_d == CHASE_ESCAPE);
    end
  end

endmodule

// File: tb/tb_enemy_arrowcommander.sv
// Bench for enemy_arrowcommander: directed scenarios plus random frames against a step-vector model.
module tb_enemy_arrowcommander;

  localparam int         STALL = 4;
  localparam int         ESC   = 32;
  localparam logic [7:0] SEED  = 8'hA5;

  localparam int M_OFF = 0, M_WAIT = 1, M_CHASE = 2, M_DETOUR = 3;

  logic clk = 1'b0;
  logic reset, startOfFrame, enable, player_awake;
  logic signed [10:0] player_topLeftX, player_topLeftY, enemy_topLeftX, enemy_topLeftY;
  logic leftArrow, rightArrow, upArrow, downArrow, chasing;

  int checks = 0;
  int errors = 0;

  int cur_ex, cur_ey, cur_px, cur_py;

  // Model: mode, unit step vector (sx,sy), last seen enemy position, frozen-run length,
  // detour frames remaining, whether the detour was already reversed, LFSR value
  int         m_mode, m_sx, m_sy, m_lastx, m_lasty, m_run, m_left;
  bit         m_used;
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  enemy_arrowcommander #(
    .CELL_BITS     (5),
    .STALL_FRAMES  (STALL),
    .ESCAPE_FRAMES (ESC),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .enable          (enable),
    .player_awake    (player_awake),
    .player_topLeftX (player_topLeftX),
    .player_topLeftY (player_topLeftY),
    .enemy_topLeftX  (enemy_topLeftX),
    .enemy_topLeftY  (enemy_topLeftY),
    .leftArrow       (leftArrow),
    .rightArrow      (rightArrow),
    .upArrow         (upArrow),
    .downArrow       (downArrow),
    .chasing         (chasing)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Point the step vector at the player along the larger gap
  task automatic aim(input int dx, input int dy, input bit tie);
    m_sx = 0;
    m_sy = 0;
    if (dx == 0 && dy == 0) begin
      m_mode = M_WAIT;
    end else begin
      if (iabs(dx) > iabs(dy) || (iabs(dx) == iabs(dy) && tie)) m_sx = sgn(dx);
      else m_sy = sgn(dy);
      m_mode = M_CHASE;
    end
  endtask

  task automatic model_step();
    int dx, dy;
    bit tie, stuck;
    if (reset) begin
      m_mode = M_OFF; m_sx = 0; m_sy = 0; m_run = 0; m_left = 0; m_used = 0;
      m_lastx = 0; m_lasty = 0; m_lfsr = SEED;
      return;
    end
    tie = m_lfsr[0];
    dx  = cur_px - cur_ex;
    dy  = cur_py - cur_ey;
    if (!(enable && player_awake)) begin
      m_mode = M_OFF; m_sx = 0; m_sy = 0;
    end else if (startOfFrame) begin
      stuck   = (cur_ex == m_lastx) && (cur_ey == m_lasty);
      m_lastx = cur_ex;
      m_lasty = cur_ey;
      if (m_mode == M_OFF || m_mode == M_WAIT) begin
        m_run = 0;
        aim(dx, dy, tie);
      end else if (m_mode == M_CHASE) begin
        m_run = stuck ? m_run + 1 : 0;
        if (m_run >= STALL) begin
          if (m_sx != 0) begin
            m_sx = 0;
            m_sy = (dy != 0) ? sgn(dy) : (tie ? 1 : -1);
          end else begin
            m_sy = 0;
            m_sx = (dx != 0) ? sgn(dx) : (tie ? 1 : -1);
          end
          m_mode = M_DETOUR; m_left = ESC; m_run = 0; m_used = 0;
        end else if (cur_ex % 32 == 0 && cur_ey % 32 == 0) begin
          aim(dx, dy, tie);
        end
      end else begin
        m_run = stuck ? m_run + 1 : 0;
        if (m_run >= STALL) begin
          m_run = 0;
          if (!m_used) begin
            m_sx = -m_sx; m_sy = -m_sy; m_left = ESC; m_used = 1;
          end else begin
            m_mode = M_WAIT;
          end
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_WAIT;
        end
      end
    end
    if (startOfFrame) m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic tick(input bit sof);
    startOfFrame = sof;
    model_step();
    @(posedge clk);
    #1;
    check("arrows", 8'({leftArrow, rightArrow, upArrow, downArrow}),
          8'({m_sx < 0, m_sx > 0, m_sy < 0, m_sy > 0}));
    check("chasing", 8'(chasing), 8'(m_mode == M_CHASE || m_mode == M_DETOUR));
    check("onehot", 8'($countones({leftArrow, rightArrow, upArrow, downArrow}) <= 1), 8'd1);
    check("lfsr", dut.u_lfsr.lfsr_q, m_lfsr);
  endtask

  task automatic frame(input int gap);
    tick(1'b1);
    repeat (gap) tick(1'b0);
  endtask

  task automatic pos(input int ex, input int ey, input int px, input int py);
    cur_ex = ex; cur_ey = ey; cur_px = px; cur_py = py;
    enemy_topLeftX  = 11'(ex);
    enemy_topLeftY  = 11'(ey);
    player_topLeftX = 11'(px);
    player_topLeftY = 11'(py);
  endtask

  function automatic int keep_in(input int v);
    return (v > 960 || v < -960) ? 0 : v;
  endfunction

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b0; player_awake = 1'b0;
    pos(0, 0, 0, 0);
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;

    // Plain chase left
    enable = 1'b1; player_awake = 1'b1;
    pos(224, 448, 96, 448);
    tick(1'b0);
    frame(2);
    for (int i = 1; i <= 6; i++) begin
      pos(224 - 8 * i, 448, 96, 448);
      frame(1);
    end

    // Diagonal tie resolved by the LFSR
    reset = 1'b1; tick(1'b0); reset = 1'b0;
    pos(224, 448, 288, 384);
    frame(2);

    // Frozen while moving right: detour up, held for the escape period
    pos(224, 448, 288, 416);
    repeat (4) frame(1);
    for (int i = 1; i <= 34; i++) begin
      pos(224, 448 - i, 288, 416);
      frame(1);
    end

    // Frozen again: detour, reversal, then give up and re-decide
    repeat (14) frame(1);
    repeat (3) frame(1);
    frame(1);
    frame(1);
    // Reset in the middle of a detour
    reset = 1'b1; tick(1'b0); reset = 1'b0;
    tick(1'b0);

    // Unaligned: hold right until the cell corner, then turn down
    pos(224, 448, 300, 448);
    frame(1);
    for (int k = 1; k <= 20; k++) begin
      pos(228 + 2 * k, 448, 300, 800);
      frame(1);
    end

    // Player dies mid-chase, then comes back
    player_awake = 1'b0;
    tick(1'b0);
    tick(1'b0);
    player_awake = 1'b1;
    tick(1'b0);
    tick(1'b0);
    frame(1);

    // Abort coinciding with a frame pulse
    enable = 1'b0;
    frame(1);
    enable = 1'b1;
    frame(1);

    // Random frames
    for (int n = 0; n < 500; n++) begin
      int ex, ey, px, py, d;
      ex = cur_ex; ey = cur_ey; px = cur_px; py = cur_py;
      reset        = ($urandom_range(0, 199) == 0);
      enable       = ($urandom_range(0, 49) != 0);
      player_awake = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ;
        5, 6, 7: begin
          ex = (ex / 32) * 32;
          ey = (ey / 32) * 32;
          case ($urandom_range(0, 3))
            0: ex += 32;
            1: ex -= 32;
            2: ey += 32;
            default: ey -= 32;
          endcase
        end
        default: begin
          ex += int'($urandom_range(0, 8)) - 4;
          ey += int'($urandom_range(0, 8)) - 4;
        end
      endcase
      case ($urandom_range(0, 19))
        0: begin px = ex; py = ey; end
        1, 2: begin
          d  = 32 * int'($urandom_range(1, 4));
          px = ex + d;
          py = $urandom_range(0, 1) ? ey + d : ey - d;
        end
        3, 4, 5: begin
          px = 32 * int'($urandom_range(0, 28)) - 448;
          py = 32 * int'($urandom_range(0, 28)) - 448;
        end
        default: ;
      endcase
      pos(keep_in(ex), keep_in(ey), keep_in(px), keep_in(py));
      frame(int'($urandom_range(0, 3)));
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
